// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART programming loader.
// Covers loader and receiver state encodings, header bytes and bit-timing derivation.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] HDR_IMEM = 8'hA0;
  localparam logic [7:0] HDR_DMEM = 8'hA1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, centre-sampled bits, glitch-rejecting start check.
// byte_valid_o / frame_err_o pulse for one cycle right after the stop-bit sample.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             rx_p0, rx_p1, rx_p2;
  logic             tick, cnt_clr, take_bit, fire_vld, fire_err;

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    take_bit = 1'b0;
    fire_vld = 1'b0;
    fire_err = 1'b0;
    tick     = (state_q == RX_START) ? (cnt_q == CNT_HALF) : (cnt_q == CNT_BIT);
    unique case (state_q)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_p2 && !rx_p1) state_d = RX_START;
      end
      // a start bit that is high again at mid-bit was only a glitch
      RX_START: if (tick) begin
        cnt_clr = 1'b1;
        state_d = rx_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        cnt_clr  = 1'b1;
        take_bit = 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (tick) begin
        cnt_clr  = 1'b1;
        state_d  = RX_IDLE;
        fire_vld = rx_p1;
        fire_err = !rx_p1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      rx_p0        <= 1'b1;
      rx_p1        <= 1'b1;
      rx_p2        <= 1'b1;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_p0        <= rx_i;
      rx_p1        <= rx_p0;
      rx_p2        <= rx_p1;
      state_q      <= state_d;
      cnt_q        <= cnt_clr ? '0 : cnt_q + 1'b1;
      byte_valid_o <= fire_vld;
      frame_err_o  <= fire_err;
      if (state_q == RX_IDLE) bit_q <= '0;
      else if (take_bit)      bit_q <= bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (take_bit) shreg_q <= {rx_p1, shreg_q[7:1]};
  end

  assign byte_o = shreg_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser driving the UPG RAM programming port from a UART byte stream.
// Frame: header (A0 imem / A1 dmem), 16-bit LE word count, then little-endian words.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_addr_o,
  output logic [31:0]       upg_data_o,
  output logic              upg_sel_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]      MAX_WORDS = 17'd1 << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [7:0]        rx_byte;
  logic              rx_vld, rx_ferr;
  logic              sel_q, err_q, wen_q, hdr_seen_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [15:0]       len_q;
  logic [23:0]       asm_q;
  logic [31:0]       data_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [15:0]       n_rx;
  logic              hdr_ok, last_word, busy;
  logic              set_err, clr_sess, tmo_on;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst_n_i      (rst_n_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (rx_ferr)
  );

  assign n_rx      = {rx_byte, len_q[7:0]};
  assign hdr_ok    = (rx_byte == HDR_IMEM) || (rx_byte == HDR_DMEM);
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};
  assign busy      = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d  = state_q;
    set_err  = 1'b0;
    clr_sess = 1'b0;
    tmo_on   = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d  = HDR;
        clr_sess = 1'b1;
      end
      // the idle timer only runs once the sender has produced a first byte
      HDR: begin
        tmo_on = hdr_seen_q;
        if (rx_vld) begin
          if (hdr_ok) state_d = LEN_LO;
          else        set_err = 1'b1;
        end
      end
      LEN_LO: begin
        tmo_on = 1'b1;
        if (rx_vld) state_d = LEN_HI;
      end
      LEN_HI: begin
        tmo_on = 1'b1;
        if (rx_vld) begin
          if (n_rx == 16'd0) begin
            state_d = DONE;
          end else if ({1'b0, n_rx} > MAX_WORDS) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        tmo_on = 1'b1;
        if (wen_q && last_word) state_d = DONE;
      end
      DONE: if (start_i) begin
        state_d  = HDR;
        clr_sess = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (busy && rx_ferr) begin
      set_err = 1'b1;
      state_d = IDLE;
    end
    if (tmo_on && !rx_vld && (tmo_q == TMO_LAST)) begin
      set_err = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      hdr_seen_q <= 1'b0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= 1'b0;
      if (set_err)       err_q <= 1'b1;
      else if (clr_sess) err_q <= 1'b0;
      if (tmo_on && !rx_vld) tmo_q <= tmo_q + 1'b1;
      else                   tmo_q <= '0;
      if (state_q == HDR && rx_vld) begin
        hdr_seen_q <= 1'b1;
        if (hdr_ok) sel_q <= (rx_byte == HDR_DMEM);
      end
      // the 4th byte of a word completes it; strobe goes out on the following cycle
      if (state_q == DATA && rx_vld) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (byte_cnt_q == 2'd3) begin
          wen_q  <= 1'b1;
          data_q <= {rx_byte, asm_q};
        end
      end
      if (wen_q) word_cnt_q <= word_cnt_q + 1'b1;
      if (clr_sess) begin
        hdr_seen_q <= 1'b0;
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LEN_LO && rx_vld) len_q[7:0]  <= rx_byte;
    if (state_q == LEN_HI && rx_vld) len_q[15:8] <= rx_byte;
    if (state_q == DATA && rx_vld) begin
      case (byte_cnt_q)
        2'd0:    asm_q[7:0]   <= rx_byte;
        2'd1:    asm_q[15:8]  <= rx_byte;
        2'd2:    asm_q[23:16] <= rx_byte;
        default: ;
      endcase
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_addr_o = word_cnt_q[ADDR_W-1:0];
  assign upg_data_o = data_q;
  assign upg_sel_o  = sel_q;
  assign upg_done_o = (state_q == DONE);
  assign busy_o     = busy;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial frames in, UPG strobes compared to a frame-level model.
module tb_uart_prog_loader;

  localparam int CLK_FREQ    = 1_600_000;
  localparam int BAUD        = 100_000;
  localparam int ADDR_W      = 3;
  localparam int TIMEOUT_CYC = 2000;
  localparam int CPB         = CLK_FREQ / BAUD;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx = 1'b1;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_addr_o;
  logic [31:0]       upg_data_o;
  logic              upg_sel_o, upg_done_o, busy_o, err_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] stream[$];
  wr_t  exp_q[$];
  wr_t  got_q[$];
  bit   exp_sel, exp_done, exp_err;
  int   cyc = 0;
  int   last_strobe_cyc = -1;
  int   done_rise_cyc = -1;
  int   dbl_wen = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .rx_i       (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_addr_o (upg_addr_o),
    .upg_data_o (upg_data_o),
    .upg_sel_o  (upg_sel_o),
    .upg_done_o (upg_done_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // Strobe monitor, sampled mid-cycle
  initial begin : monitor
    logic prev_wen, prev_done;
    wr_t  w;
    prev_wen  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (upg_wen_o === 1'b1) begin
        w.addr = upg_addr_o;
        w.data = upg_data_o;
        got_q.push_back(w);
        last_strobe_cyc = cyc;
        if (prev_wen) dbl_wen++;
      end
      if (upg_done_o === 1'b1 && !prev_done) done_rise_cyc = cyc;
      prev_wen  = upg_wen_o;
      prev_done = upg_done_o;
    end
  end

  task automatic clear_obs();
    got_q.delete();
    last_strobe_cyc = -1;
    done_rise_cyc   = -1;
    dbl_wen         = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // start_at >= 0 raises start_i in the gap after that byte index
  task automatic send_stream(input int start_at, input int max_gap);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], 1'b0, $urandom_range(0, max_gap));
      if (i == start_at) pulse_start();
    end
    repeat (4) @(negedge clk);
  endtask

  // Frame-level reference: skip junk until a header, read count, collect whole LE words
  task automatic model_stream();
    int  p, n;
    wr_t w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    p = 0;
    while (p < stream.size() && stream[p] != 8'hA0 && stream[p] != 8'hA1) begin
      exp_err = 1'b1;
      p++;
    end
    if (p + 2 >= stream.size()) return;
    exp_sel = (stream[p] == 8'hA1);
    n = int'(stream[p+1]) + 256 * int'(stream[p+2]);
    p += 3;
    if (n > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n && p + 3 < stream.size(); k++) begin
      w.addr = k[ADDR_W-1:0];
      w.data = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
      exp_q.push_back(w);
      p += 4;
    end
    exp_done = (exp_q.size() == n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({upg_wen_o, upg_addr_o, upg_data_o, upg_sel_o, upg_done_o, busy_o, err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h sel=%b done=%b busy=%b err=%b, want all 0",
               upg_wen_o, upg_addr_o, upg_data_o, upg_sel_o, upg_done_o, busy_o, err_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_obs();
    stream = '{8'hA1, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_stream();
    pulse_start();
    send_stream(-1, 2);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_word%0d: got addr %0d data %h, want addr %0d data %h",
                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_cmp++;
    if ({upg_sel_o, upg_done_o, err_o, busy_o} !== {exp_sel, exp_done, exp_err, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_flags: got sel/done/err/busy %b%b%b%b, want %b%b%b0",
               upg_sel_o, upg_done_o, err_o, busy_o, exp_sel, exp_done, exp_err);
    end
    n_cmp++;
    if (done_rise_cyc != last_strobe_cyc + 1) begin
      n_bad++;
      $display("FAIL basic_done_latency: done rose at %0d, want %0d", done_rise_cyc, last_strobe_cyc + 1);
    end
    n_cmp++;
    if (dbl_wen != 0) begin
      n_bad++;
      $display("FAIL basic_wen_width: got %0d multi-cycle strobes, want 0", dbl_wen);
    end
  endtask

  task automatic test_hdr_resync();
    clear_obs();
    stream = '{8'h55, 8'hA0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    model_stream();
    pulse_start();
    n_cmp++;
    if (upg_done_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL resync_start_clears: got done=%b err=%b, want 0 0", upg_done_o, err_o);
    end
    send_stream(-1, 3);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL resync_count: got %0d strobes, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL resync_word%0d: got addr %0d data %h, want addr %0d data %h",
                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_cmp++;
    if ({upg_sel_o, upg_done_o, err_o} !== {exp_sel, exp_done, exp_err}) begin
      n_bad++;
      $display("FAIL resync_flags: got sel/done/err %b%b%b, want %b%b%b",
               upg_sel_o, upg_done_o, err_o, exp_sel, exp_done, exp_err);
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    pulse_start();
    send_byte(8'hA0, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    n_cmp++;
    if ({upg_done_o, busy_o, err_o} !== 3'b100 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL zero_len: got done/busy/err %b%b%b strobes %0d, want 100 strobes 0",
               upg_done_o, busy_o, err_o, got_q.size());
    end
  endtask

  task automatic test_oversize();
    clear_obs();
    pulse_start();
    send_byte(8'hA0, 1'b0, 0);
    send_byte(8'((1 << ADDR_W) + 1), 1'b0, 0);
    send_byte(8'h00, 1'b0, 4);
    n_cmp++;
    if ({upg_done_o, busy_o, err_o} !== 3'b001 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL oversize: got done/busy/err %b%b%b strobes %0d, want 001 strobes 0",
               upg_done_o, busy_o, err_o, got_q.size());
    end
    pulse_start();
    n_cmp++;
    if ({busy_o, err_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL start_clears_err: got busy/err %b%b, want 10", busy_o, err_o);
    end
  endtask

  task automatic test_hdr_wait();
    clear_obs();
    pulse_start();
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    n_cmp++;
    if ({busy_o, err_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL hdr_wait_no_timeout: got busy/err %b%b, want 10", busy_o, err_o);
    end
    stream = '{8'hA1, 8'h01, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90};
    send_stream(-1, 1);
    n_cmp++;
    if (got_q.size() != 1 || {upg_done_o, upg_sel_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL hdr_wait_frame: got strobes %0d done/sel %b%b, want 1 11",
               got_q.size(), upg_done_o, upg_sel_o);
    end else begin
      n_cmp++;
      if (got_q[0].data !== 32'h90A1B2C3) begin
        n_bad++;
        $display("FAIL hdr_wait_data: got %h, want 90a1b2c3", got_q[0].data);
      end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    stream = '{8'hA0, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    model_stream();
    pulse_start();
    send_stream(-1, 2);
    repeat (TIMEOUT_CYC - 200) @(negedge clk);
    n_cmp++;
    if ({busy_o, err_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL timeout_early: got busy/err %b%b before limit, want 10", busy_o, err_o);
    end
    repeat (220) @(negedge clk);
    n_cmp++;
    if ({busy_o, err_o, upg_done_o} !== 3'b010) begin
      n_bad++;
      $display("FAIL timeout_flags: got busy/err/done %b%b%b, want 010", busy_o, err_o, upg_done_o);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size() || (got_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      n_bad++;
      $display("FAIL timeout_strobes: got %0d strobes, want %0d (addr 0 data %h)",
               got_q.size(), exp_q.size(), exp_q[0].data);
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    pulse_start();
    send_byte(8'hA0, 1'b0, 1);
    send_byte(8'h02, 1'b0, 1);
    send_byte(8'h00, 1'b0, 1);
    send_byte(8'($urandom_range(0, 255)), 1'b0, 1);
    send_byte(8'($urandom_range(0, 255)), 1'b1, 4);
    n_cmp++;
    if ({busy_o, err_o, upg_done_o} !== 3'b010 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL frame_err: got busy/err/done %b%b%b strobes %0d, want 010 strobes 0",
               busy_o, err_o, upg_done_o, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    pulse_start();
    stream = '{8'hA1, 8'h02, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'hBA, 8'h01, 8'h02};
    send_stream(-1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({upg_wen_o, upg_addr_o, upg_data_o, upg_sel_o, upg_done_o, busy_o, err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got addr=%0d data=%h sel=%b busy=%b, want all 0",
               upg_addr_o, upg_data_o, upg_sel_o, busy_o);
    end
    got_q.delete();
    repeat (CPB * 3) @(negedge clk);
    send_byte(8'h03, 1'b0, 1);
    send_byte(8'h04, 1'b0, 8);
    n_cmp++;
    if (got_q.size() != 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d strobes busy=%b, want 0 0", got_q.size(), busy_o);
    end
    clear_obs();
    stream = '{8'hA0, 8'h01, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01};
    model_stream();
    pulse_start();
    send_stream(-1, 2);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || {upg_done_o, upg_sel_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_mid_restart: got %0d strobes done/sel %b%b, want 1 (addr 0 data %h) 10",
               got_q.size(), upg_done_o, upg_sel_o, exp_q[0].data);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] j;
    for (int s = 0; s < 4; s++) begin
      clear_obs();
      stream.delete();
      if ($urandom_range(0, 1) == 1) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA0 || j == 8'hA1) j = 8'h5A;
        stream.push_back(j);
      end
      stream.push_back(8'hA0 | 8'($urandom_range(0, 1)));
      n = (s == 0) ? (1 << ADDR_W) : $urandom_range(1, 1 << ADDR_W);
      stream.push_back(8'(n));
      stream.push_back(8'h00);
      for (int b = 0; b < 4 * n; b++) stream.push_back(8'($urandom_range(0, 255)));
      model_stream();
      pulse_start();
      send_stream(stream.size() - 3, (s == 3) ? 0 : 3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rand%0d_count: got %0d strobes, want %0d", s, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand%0d_word%0d: got addr %0d data %h, want addr %0d data %h",
                   s, i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
      n_cmp++;
      if ({upg_sel_o, upg_done_o, err_o, busy_o} !== {exp_sel, exp_done, exp_err, 1'b0}) begin
        n_bad++;
        $display("FAIL rand%0d_flags: got sel/done/err/busy %b%b%b%b, want %b%b%b0",
                 s, upg_sel_o, upg_done_o, err_o, busy_o, exp_sel, exp_done, exp_err);
      end
      n_cmp++;
      if (done_rise_cyc != last_strobe_cyc + 1 || dbl_wen != 0) begin
        n_bad++;
        $display("FAIL rand%0d_timing: done rose at %0d after strobe at %0d, long strobes %0d, want +1 and 0",
                 s, done_rise_cyc, last_strobe_cyc, dbl_wen);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_hdr_resync();
    test_zero_len();
    test_oversize();
    test_hdr_wait();
    test_timeout();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
